// File: rtl/ccu_ax_sched.sv
// ccu_ax_sched: round-robin scheduler for per-core AX requests toward the CCU.
// The grant is held until the CCU accepts it, and each port is limited to MaxOutstanding transactions.
module ccu_ax_sched #(
  parameter int NoPorts        = 2,
  parameter int MaxOutstanding = 4,
  localparam int IdxW = $clog2(NoPorts),
  localparam int CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NoPorts-1:0] req_valid_i,
  input  logic [NoPorts-1:0] req_write_i,
  output logic [NoPorts-1:0] req_ready_o,
  output logic               gnt_valid_o,
  output logic [IdxW-1:0]    gnt_idx_o,
  output logic               gnt_write_o,
  input  logic               gnt_ready_i,
  input  logic [NoPorts-1:0] done_i,
  output logic [NoPorts-1:0] busy_o
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic            gwr_q, gwr_d;
  logic [CntW-1:0] cnt_q [NoPorts];
  logic [CntW-1:0] cnt_d [NoPorts];

  logic [NoPorts-1:0] elig;
  logic [NoPorts-1:0] inc;
  logic [NoPorts-1:0] dec;
  logic               handshake;
  logic [IdxW-1:0]    scan_base;
  logic               scan_hit;
  logic [IdxW-1:0]    scan_idx;

  assign handshake = (state_q == HOLD) && gnt_ready_i;

  always_comb begin
    elig = '0;
    for (int p = 0; p < NoPorts; p++) begin
      elig[p] = req_valid_i[p] && (cnt_q[p] < CntW'(MaxOutstanding));
    end
  end

  // In HOLD the scan starts after the current grant and skips it, so a handshake
  // can hand over to the next requester without an idle cycle.
  always_comb begin
    logic [IdxW:0] pos;
    pos       = '0;
    scan_hit  = 1'b0;
    scan_idx  = '0;
    scan_base = (state_q == HOLD) ? gidx_q : ptr_q;
    for (int i = 1; i <= NoPorts; i++) begin
      pos = {1'b0, scan_base} + (IdxW+1)'(i);
      if (pos >= (IdxW+1)'(NoPorts)) begin
        pos = pos - (IdxW+1)'(NoPorts);
      end
      if (!scan_hit && elig[pos[IdxW-1:0]] &&
          !((state_q == HOLD) && (pos[IdxW-1:0] == gidx_q))) begin
        scan_hit = 1'b1;
        scan_idx = pos[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gwr_d   = gwr_q;
    unique case (state_q)
      IDLE: begin
        if (scan_hit) begin
          state_d = HOLD;
          gidx_d  = scan_idx;
          gwr_d   = req_write_i[scan_idx];
        end
      end
      HOLD: begin
        if (gnt_ready_i) begin
          ptr_d = gidx_q;
          if (scan_hit) begin
            gidx_d = scan_idx;
            gwr_d  = req_write_i[scan_idx];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A done on an empty counter is dropped; a grant and a done on the same port cancel out.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int p = 0; p < NoPorts; p++) begin
      cnt_d[p] = cnt_q[p];
      inc[p]   = handshake && (gidx_q == IdxW'(p)) && (cnt_q[p] < CntW'(MaxOutstanding));
      dec[p]   = done_i[p] && (cnt_q[p] != '0);
      if (inc[p] && !dec[p]) begin
        cnt_d[p] = cnt_q[p] + CntW'(1);
      end else if (dec[p] && !inc[p]) begin
        cnt_d[p] = cnt_q[p] - CntW'(1);
      end
    end
  end

  // The pointer resets to the last port so that port 0 wins the first scan.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= IdxW'(NoPorts - 1);
      gidx_q  <= '0;
      gwr_q   <= 1'b0;
      for (int p = 0; p < NoPorts; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gwr_q   <= gwr_d;
      for (int p = 0; p < NoPorts; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    gnt_write_o = 1'b0;
    if (state_q == HOLD) begin
      gnt_valid_o         = 1'b1;
      gnt_idx_o           = gidx_q;
      gnt_write_o         = gwr_q;
      req_ready_o[gidx_q] = gnt_ready_i;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int p = 0; p < NoPorts; p++) begin
      busy_o[p] = (cnt_q[p] != '0);
    end
  end

`ifndef SYNTHESIS
  // A requester must keep its request up until the held grant is accepted.
  req_held_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == HOLD) |-> req_valid_i[gidx_q])
    else $error("ccu_ax_sched: req_valid_i dropped on held grant port %0d", gidx_q);
`endif

endmodule

// File: tb/tb_ccu_ax_sched.sv
// Directed testbench for ccu_ax_sched: a 4-port instance (limit 4) and a 2-port instance (limit 2).
module tb_ccu_ax_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] a_req_valid, a_req_write, a_req_ready, a_done, a_busy;
  logic       a_gnt_valid, a_gnt_write, a_gnt_ready;
  logic [1:0] a_gnt_idx;

  logic [1:0] b_req_valid, b_req_write, b_req_ready, b_done, b_busy;
  logic       b_gnt_valid, b_gnt_write, b_gnt_ready;
  logic [0:0] b_gnt_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  ccu_ax_sched #(.NoPorts(4), .MaxOutstanding(4)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_write_i(a_req_write), .req_ready_o(a_req_ready),
    .gnt_valid_o(a_gnt_valid), .gnt_idx_o(a_gnt_idx), .gnt_write_o(a_gnt_write),
    .gnt_ready_i(a_gnt_ready), .done_i(a_done), .busy_o(a_busy)
  );

  ccu_ax_sched #(.NoPorts(2), .MaxOutstanding(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_write_i(b_req_write), .req_ready_o(b_req_ready),
    .gnt_valid_o(b_gnt_valid), .gnt_idx_o(b_gnt_idx), .gnt_write_o(b_gnt_write),
    .gnt_ready_i(b_gnt_ready), .done_i(b_done), .busy_o(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic ready, input logic [3:0] done);
    a_req_valid = valid;
    a_gnt_ready = ready;
    a_done      = done;
    #1;
  endtask

  logic exp_b [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    a_req_valid = '0; a_req_write = 4'b1010; a_gnt_ready = 1'b0; a_done = '0;
    b_req_valid = '0; b_req_write = 2'b10;   b_gnt_ready = 1'b0; b_done = '0;
    tick();
    tick();
    checkOutput("rst_gnt_valid", 32'(a_gnt_valid), 0);
    checkOutput("rst_gnt_idx",   32'(a_gnt_idx),   0);
    checkOutput("rst_req_ready", 32'(a_req_ready), 0);
    checkOutput("rst_busy",      32'(a_busy),      0);
    checkOutput("rst_b_valid",   32'(b_gnt_valid), 0);

    // Two requesters with the CCU always ready alternate 0,1,0,1.
    rst_n = 1'b1;
    applyStimulus(4'b0011, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rr_valid", 32'(a_gnt_valid), 1);
      checkOutput("rr_idx",   32'(a_gnt_idx),   i % 2);
      checkOutput("rr_write", 32'(a_gnt_write), i % 2);
      checkOutput("rr_ready", 32'(a_req_ready), (i % 2) ? 'b0010 : 'b0001);
    end
    applyStimulus(4'b0010, 1'b1, 4'b0000);
    tick();
    checkOutput("drain_valid", 32'(a_gnt_valid), 0);
    checkOutput("drain_busy",  32'(a_busy),      'b0011);
    applyStimulus(4'b0000, 1'b1, 4'b0011);
    tick();
    checkOutput("done_busy1", 32'(a_busy), 'b0011);
    applyStimulus(4'b0000, 1'b1, 4'b0010);
    tick();
    checkOutput("done_busy2", 32'(a_busy), 'b0001);

    // Port 0 holds one outstanding; its handshake coincides with a done.
    applyStimulus(4'b0001, 1'b0, 4'b0000);
    tick();
    checkOutput("sim_gnt_idx", 32'(a_gnt_idx), 0);
    applyStimulus(4'b0001, 1'b1, 4'b0001);
    checkOutput("sim_ready", 32'(a_req_ready), 'b0001);
    tick();
    applyStimulus(4'b0000, 1'b1, 4'b0000);
    checkOutput("sim_valid", 32'(a_gnt_valid), 0);
    checkOutput("sim_busy",  32'(a_busy),      'b0001);
    applyStimulus(4'b0000, 1'b1, 4'b0001);
    tick();
    applyStimulus(4'b0000, 1'b1, 4'b0000);
    checkOutput("sim_drain", 32'(a_busy), 0);

    // A done on an idle port must not wrap its counter.
    applyStimulus(4'b0000, 1'b0, 4'b1000);
    tick();
    applyStimulus(4'b0000, 1'b0, 4'b0000);
    checkOutput("udf_busy", 32'(a_busy), 0);
    applyStimulus(4'b1000, 1'b0, 4'b0000);
    tick();
    checkOutput("udf_valid", 32'(a_gnt_valid), 1);
    checkOutput("udf_idx",   32'(a_gnt_idx),   3);
    checkOutput("udf_write", 32'(a_gnt_write), 1);

    // Stalled CCU: grant must stay put with no ready.
    applyStimulus(4'b1111, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", 32'(a_gnt_valid), 1);
      checkOutput("stall_idx",   32'(a_gnt_idx),   3);
      checkOutput("stall_write", 32'(a_gnt_write), 1);
      checkOutput("stall_ready", 32'(a_req_ready), 0);
    end
    applyStimulus(4'b1111, 1'b1, 4'b0000);
    checkOutput("rel_ready", 32'(a_req_ready), 'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rel_idx",   32'(a_gnt_idx),   i);
      checkOutput("rel_ready", 32'(a_req_ready), 1 << i);
    end

    // Build three outstanding on port 2, then reset in the middle of a held grant.
    applyStimulus(4'b0100, 1'b1, 4'b0000);
    tick();
    checkOutput("p2_valid0", 32'(a_gnt_valid), 0);
    tick();
    checkOutput("p2_idx1",   32'(a_gnt_idx),   2);
    checkOutput("p2_valid1", 32'(a_gnt_valid), 1);
    tick();
    checkOutput("p2_valid2", 32'(a_gnt_valid), 0);
    tick();
    checkOutput("p2_valid3", 32'(a_gnt_valid), 1);
    tick();
    checkOutput("p2_valid4", 32'(a_gnt_valid), 0);
    checkOutput("p2_busy",   32'(a_busy),      'b1111);
    applyStimulus(4'b0100, 1'b0, 4'b0000);
    tick();
    checkOutput("p2_hold_valid", 32'(a_gnt_valid), 1);
    checkOutput("p2_hold_idx",   32'(a_gnt_idx),   2);
    applyStimulus(4'b0100, 1'b1, 4'b0000);
    checkOutput("p2_hold_ready", 32'(a_req_ready), 'b0100);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(a_gnt_valid), 0);
    checkOutput("arst_idx",   32'(a_gnt_idx),   0);
    checkOutput("arst_write", 32'(a_gnt_write), 0);
    checkOutput("arst_ready", 32'(a_req_ready), 0);
    checkOutput("arst_busy",  32'(a_busy),      0);
    applyStimulus(4'b1111, 1'b1, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_valid", 32'(a_gnt_valid), 1);
    checkOutput("post_rst_idx",   32'(a_gnt_idx),   0);
    checkOutput("post_rst_busy",  32'(a_busy),      0);

    // Port 1 alone against a limit of two outstanding.
    b_req_valid = 2'b10;
    b_gnt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("lim_valid", 32'(b_gnt_valid), 32'(exp_b[i]));
      if (exp_b[i]) begin
        checkOutput("lim_idx", 32'(b_gnt_idx), 1);
      end
    end
    checkOutput("lim_busy", 32'(b_busy), 'b10);
    b_done = 2'b10;
    tick();
    b_done = 2'b00;
    #1;
    checkOutput("lim_done_valid", 32'(b_gnt_valid), 0);
    tick();
    checkOutput("lim_third_valid", 32'(b_gnt_valid), 1);
    checkOutput("lim_third_idx",   32'(b_gnt_idx),   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ccu_ax_sched.md
CCU_AX_SCHED -- requirements
Module: ccu_ax_sched

Interface
REQ-001 SHALL have parameter NoPorts, default 2, meaning number of requesting core ports (legal range 2..16).
REQ-002 SHALL have parameter MaxOutstanding, default 4, meaning per-port limit of granted but not yet completed transactions (legal range 1..15).
REQ-003 SHALL derive IdxW = $clog2(NoPorts) and CntW = $clog2(MaxOutstanding+1); neither is user-overridable.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on the rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset: asynchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, NoPorts, per-port AX request pending.
REQ-007 SHALL have port req_write_i, input, NoPorts, per-port request type: 1 = AW, 0 = AR.
REQ-008 SHALL have port req_ready_o, output, NoPorts, per-port request accepted this cycle.
REQ-009 SHALL have port gnt_valid_o, output, 1, a granted request is presented to the CCU.
REQ-010 SHALL have port gnt_idx_o, output, IdxW, index of the granted port.
REQ-011 SHALL have port gnt_write_o, output, 1, type of the granted request.
REQ-012 SHALL have port gnt_ready_i, input, 1, the CCU accepts the granted request.
REQ-013 SHALL have port done_i, input, NoPorts, per-port completion pulse (B handshake or R-last handshake).
REQ-014 SHALL have port busy_o, output, NoPorts, per-port outstanding count nonzero.

Function
REQ-015 SHALL implement FSM states IDLE and HOLD, plus a round-robin pointer ptr_q (IdxW bits) and per-port counters cnt_q[p] (CntW bits).
REQ-016 SHALL treat port p as eligible when req_valid_i[p]=1 and cnt_q[p] < MaxOutstanding.
REQ-017 SHALL select, in IDLE, the first eligible port scanning ptr_q+1, ptr_q+2, ... modulo NoPorts; it SHALL latch the port's index and req_write_i into gidx_q and gwr_q and go to HOLD next cycle.
REQ-018 SHALL remain in IDLE and drive no grant when no port is eligible.
REQ-019 SHALL drive gnt_valid_o=1, gnt_idx_o=gidx_q and gnt_write_o=gwr_q only in HOLD; in IDLE these outputs SHALL be 0.
REQ-020 SHALL drive req_ready_o[gidx_q]=gnt_ready_i in HOLD and req_ready_o=0 for all other ports and in IDLE (purely combinational path, no added latency).
REQ-021 SHALL keep the grant stable (idx, write) in HOLD until gnt_valid_o & gnt_ready_i; grants SHALL NOT be revoked.
REQ-022 SHALL, on the HOLD handshake, set ptr_q=gidx_q, increment cnt_q[gidx_q], and evaluate eligibility that same cycle from the updated pointer, excluding the just-granted port's old request. If another port is eligible, the FSM SHALL stay in HOLD with the new grant next cycle (back-to-back); otherwise it SHALL return to IDLE.
REQ-023 SHALL give a latency from first eligibility in IDLE to gnt_valid_o of exactly 1 cycle, and a sustained throughput of one grant per cycle under back-to-back handshakes.
REQ-024 SHALL decrement cnt_q[p] on done_i[p]=1; done_i[p] while cnt_q[p]=0 SHALL be ignored (no underflow).
REQ-025 SHALL leave cnt_q[p] unchanged on a simultaneous increment and decrement of the same port.
REQ-026 SHALL never let cnt_q[p] exceed MaxOutstanding; a port at the limit SHALL be skipped by the scan until a done_i[p] arrives.
REQ-027 SHALL drive busy_o[p] = (cnt_q[p] != 0), taken from registered state.
REQ-028 SHALL treat req_valid_i[gidx_q] falling while in HOLD as a requester protocol violation; the grant SHALL still be held, and an assertion SHALL flag it in simulation.

Reset
REQ-029 SHALL, on rst_ni low at any time (including mid-HOLD), immediately force: state IDLE, ptr_q=NoPorts-1 (so port 0 wins first), all cnt_q=0, gidx_q=0, gwr_q=0, and all outputs 0.
REQ-030 SHALL resume arbitration on the first rising clk_i edge after rst_ni deasserts.

Verification
REQ-031 Reset, then req_valid_i=2'b11 held -> gnt_idx_o=0 at cycle 1; gnt_ready_i=1 constant gives grants 0,1,0,1 on consecutive cycles.
REQ-032 MaxOutstanding=2, only port 1 requesting, no done_i -> exactly 2 grants, then gnt_valid_o=0 and busy_o[1]=1; one done_i[1] pulse -> a third grant the next cycle.
REQ-033 done_i[0] pulsed in the same cycle as the port-0 handshake, with cnt_q[0]=1 -> cnt_q[0] stays 1 and busy_o[0] stays 1.
REQ-034 Hold gnt_ready_i=0 for 5 cycles with NoPorts=4 and all ports requesting -> gnt_idx_o and gnt_write_o stay constant and req_ready_o=0 throughout.
REQ-035 rst_ni asserted mid-HOLD with cnt_q[2]=3 -> all outputs 0 asynchronously (before the next edge); after release, port 0 is granted first.
REQ-036 done_i[3] pulsed with cnt_q[3]=0 -> cnt_q[3] stays 0, with no wrap to 2^CntW-1.
